// File: rtl/tx_machine.sv
// tx_machine: transmission controller between a data source (DATA/DRDY)
// and a requesting consumer (REQ/ACK). It forwards source bytes to Y while
// REQ and DRDY are both high. It flags an exception when the consumer drops
// REQ while the source still presents data.
module tx_machine #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENA,
    input  logic             REQ,
    input  logic             DRDY,
    input  logic [WIDTH-1:0] DATA,
    output logic             ACK,
    output logic             EXC,
    output logic             IDL,
    output logic [WIDTH-1:0] Y
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_XFER = 2'b10,
        ST_EXCP = 2'b11
    } state_t;

    state_t           state_p1;
    state_t           state_nxt;
    logic             load_y;
    logic [WIDTH-1:0] y_p1;

    // Next-state decode; a low ENA returns to IDLE from every state
    always_comb begin
        state_nxt = state_p1;
        load_y    = 1'b0;
        case (state_p1)
            ST_IDLE: begin
                if (ENA && REQ) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!ENA || !REQ) begin
                    state_nxt = ST_IDLE;
                end else if (DRDY) begin
                    state_nxt = ST_XFER;
                    load_y    = 1'b1;
                end
            end
            ST_XFER: begin
                if (!ENA) begin
                    state_nxt = ST_IDLE;
                end else if (!REQ) begin
                    // Consumer withdrew: an exception only if data is still offered
                    state_nxt = DRDY ? ST_EXCP : ST_IDLE;
                end else if (DRDY) begin
                    state_nxt = ST_XFER;
                    load_y    = 1'b1;
                end else begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_EXCP: begin
                // REQ is deliberately ignored here; only the source clears it
                if (!ENA || !DRDY) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register; reset overrides every transition
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_p1 <= ST_IDLE;
        end else begin
            state_p1 <= state_nxt;
        end
    end

    // Output data register: captures DATA on each accepted byte, otherwise holds
    always_ff @(posedge CLK) begin
        if (RESET) begin
            y_p1 <= '0;
        end else if (load_y) begin
            y_p1 <= DATA;
        end
    end

    // Moore outputs, decoded only from registered state
    always_comb begin
        IDL = (state_p1 == ST_IDLE);
        ACK = (state_p1 == ST_XFER);
        EXC = (state_p1 == ST_EXCP);
        Y   = y_p1;
    end

endmodule

// File: tb/tb_tx_machine.sv
// Self-checking bench for tx_machine: directed scenarios plus random traffic
// compared against a behavioural model of the transfer protocol.
module tb_tx_machine;

    localparam int WIDTH = 8;

    logic             CLK = 1'b0;
    logic             RESET, ENA, REQ, DRDY;
    logic [WIDTH-1:0] DATA;
    logic             ACK, EXC, IDL;
    logic [WIDTH-1:0] Y;

    int errors = 0;
    int checks = 0;

    // model: mode 0=idle, 1=waiting, 2=transferring, 3=exception
    int               m_mode = 0;
    logic [WIDTH-1:0] m_y    = '0;

    tx_machine #(.WIDTH(WIDTH)) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .ENA  (ENA),
        .REQ  (REQ),
        .DRDY (DRDY),
        .DATA (DATA),
        .ACK  (ACK),
        .EXC  (EXC),
        .IDL  (IDL),
        .Y    (Y)
    );

    always #5 CLK = ~CLK;

    // Apply one cycle of inputs, advance the model at the edge, settle 1ns
    task automatic cycle(input logic rst, input logic ena, input logic req,
                         input logic drdy, input logic [WIDTH-1:0] data);
        bit accepted;
        RESET = rst; ENA = ena; REQ = req; DRDY = drdy; DATA = data;
        @(posedge CLK);
        accepted = (m_mode == 1 || m_mode == 2) && ena && req && drdy;
        if (rst) begin
            m_mode = 0;
            m_y    = '0;
        end else begin
            if (accepted) m_y = data;
            if (!ena) m_mode = 0;
            else begin
                case (m_mode)
                    0: m_mode = req ? 1 : 0;
                    1: m_mode = !req ? 0 : (drdy ? 2 : 1);
                    2: m_mode = !req ? (drdy ? 3 : 0) : (drdy ? 2 : 1);
                    default: m_mode = drdy ? 3 : 0;
                endcase
            end
        end
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 0, 8'h00);
        checks++; if (IDL !== 1'b1) begin errors++; $display("FAIL reset_idl: got %b want 1", IDL); end
        checks++; if (ACK !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", ACK); end
        checks++; if (EXC !== 1'b0) begin errors++; $display("FAIL reset_exc: got %b want 0", EXC); end
        checks++; if (Y !== 8'h00) begin errors++; $display("FAIL reset_y: got %h want 00", Y); end
    endtask

    task automatic test_disabled();
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1, 1, 8'h3C);
            checks++; if (IDL !== 1'b1) begin errors++; $display("FAIL disabled_idl[%0d]: got %b want 1", i, IDL); end
        end
        checks++; if (Y !== 8'h00) begin errors++; $display("FAIL disabled_y: got %h want 00", Y); end
    endtask

    task automatic test_basic();
        cycle(0, 1, 1, 0, 8'h11);
        checks++; if (IDL !== 1'b0 || ACK !== 1'b0) begin errors++; $display("FAIL basic_wait: got idl=%b ack=%b want idl=0 ack=0", IDL, ACK); end
        cycle(0, 1, 1, 1, 8'hAA);
        checks++; if (ACK !== 1'b1) begin errors++; $display("FAIL basic_ack: got %b want 1", ACK); end
        checks++; if (Y !== 8'hAA) begin errors++; $display("FAIL basic_y: got %h want aa", Y); end
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 1, 1, 8'hAA);
            checks++; if (ACK !== 1'b1) begin errors++; $display("FAIL basic_hold[%0d]: got %b want 1", i, ACK); end
        end
    endtask

    task automatic test_exception();
        cycle(0, 1, 0, 1, 8'hAA);
        checks++; if (EXC !== 1'b1 || ACK !== 1'b0) begin errors++; $display("FAIL exc_enter: got exc=%b ack=%b want exc=1 ack=0", EXC, ACK); end
        cycle(0, 1, 1, 1, 8'h77);
        checks++; if (EXC !== 1'b1) begin errors++; $display("FAIL exc_ignore_req: got %b want 1", EXC); end
        checks++; if (Y !== 8'hAA) begin errors++; $display("FAIL exc_y_hold: got %h want aa", Y); end
        cycle(0, 1, 0, 0, 8'h77);
        checks++; if (IDL !== 1'b1) begin errors++; $display("FAIL exc_exit_idl: got %b want 1", IDL); end
        checks++; if (Y !== 8'hAA) begin errors++; $display("FAIL exc_exit_y: got %h want aa", Y); end
    endtask

    task automatic test_stall_resume();
        logic [2:0] want;
        logic [2:0] drdy_seq;
        want = 3'b101;
        drdy_seq = 3'b101;
        cycle(0, 1, 1, 0, 8'h55);
        for (int i = 2; i >= 0; i--) begin
            cycle(0, 1, 1, drdy_seq[i], 8'h55);
            checks++; if (ACK !== want[i]) begin errors++; $display("FAIL stall_ack[%0d]: got %b want %b", 2 - i, ACK, want[i]); end
        end
        checks++; if (Y !== 8'h55) begin errors++; $display("FAIL stall_y: got %h want 55", Y); end
        cycle(0, 1, 0, 0, 8'h55);
        checks++; if (IDL !== 1'b1) begin errors++; $display("FAIL stall_idle: got %b want 1", IDL); end
    endtask

    task automatic test_enable_drop();
        cycle(0, 1, 1, 0, 8'h00);
        cycle(0, 1, 1, 1, 8'hC3);
        cycle(0, 0, 0, 1, 8'h99);
        checks++; if (IDL !== 1'b1 || EXC !== 1'b0) begin errors++; $display("FAIL ena_drop: got idl=%b exc=%b want idl=1 exc=0", IDL, EXC); end
        checks++; if (Y !== 8'hC3) begin errors++; $display("FAIL ena_drop_y: got %h want c3", Y); end
    endtask

    task automatic test_reset_mid();
        cycle(0, 1, 1, 0, 8'h00);
        cycle(0, 1, 1, 1, 8'h5A);
        cycle(1, 1, 1, 1, 8'h33);
        checks++; if (IDL !== 1'b1 || ACK !== 1'b0) begin errors++; $display("FAIL rstmid_state: got idl=%b ack=%b want idl=1 ack=0", IDL, ACK); end
        checks++; if (Y !== 8'h00) begin errors++; $display("FAIL rstmid_y: got %h want 00", Y); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                  WIDTH'($urandom));
            checks++;
            if (IDL !== (m_mode == 0) || ACK !== (m_mode == 2) ||
                EXC !== (m_mode == 3) || Y !== m_y) begin
                errors++;
                $display("FAIL random[%0d]: got idl=%b ack=%b exc=%b y=%h want mode=%0d y=%h",
                         i, IDL, ACK, EXC, Y, m_mode, m_y);
            end
        end
    endtask

    initial begin
        RESET = 1'b1; ENA = 1'b0; REQ = 1'b0; DRDY = 1'b0; DATA = '0;
        test_reset();
        test_disabled();
        test_basic();
        test_exception();
        test_stall_resume();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
